// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
// Segment bits are active-low: bit 6 = a ... bit 0 = g, bit 7 = DP.
package ssd_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam int unsigned SEG_DP_BIT = 7;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_encode.sv
// Combinational nibble to active-low seven-segment pattern (a..g on bits 6..0).
module ssd_hex_encode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-aligned
// updates, per-digit blank/blink/DP and 8-level PWM brightness.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SUB_DIV      = 12500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Load,
  input  logic [4*NUM_DIGITS-1:0]   Digits,
  input  logic [NUM_DIGITS-1:0]     Dp,
  input  logic [NUM_DIGITS-1:0]     Blank,
  input  logic [NUM_DIGITS-1:0]     Blink,
  input  logic [2:0]                Brightness,
  output logic [NUM_DIGITS-1:0]     Anode,
  output logic [7:0]                Cathode,
  output logic                      FrameTick
);

  localparam int unsigned PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(SUB_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    sub_q, sub_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;

  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                    pend_flag_q, pend_flag_d;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;
  logic                  tick_q;

  logic       pre_tc, sub_tc, frame_wrap, lit;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;

  assign pre_tc     = (pre_q == PRE_LAST);
  assign sub_tc     = pre_tc && (sub_q == 3'd7);
  assign frame_wrap = sub_tc && (dig_q == DIG_LAST);
  assign cur_nib    = act_digits_q[4*dig_q +: 4];

  ssd_hex_encode u_hex_encode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Brightness is taken live so a change shows up at the very next sub-slot.
  assign lit = (sub_q <= Brightness) && !act_blank_q[dig_q] &&
               !(act_blink_q[dig_q] && phase_q);

  always_comb begin
    pre_d        = pre_tc ? '0 : pre_q + 1'b1;
    sub_d        = pre_tc ? sub_q + 3'd1 : sub_q;
    dig_d        = dig_q;
    blk_d        = blk_q;
    phase_d      = phase_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_blink_d  = pend_blink_q;
    pend_flag_d   = pend_flag_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    act_blink_d   = act_blink_q;

    if (sub_tc) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    if (frame_wrap) begin
      blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + 1'b1;
      if (blk_q == BLK_LAST) begin
        phase_d = ~phase_q;
      end
      if (pend_flag_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
        act_blink_d  = pend_blink_q;
        pend_flag_d  = 1'b0;
      end
    end
    // A Load on the boundary cycle wins the flag and waits for the next frame.
    if (Load) begin
      pend_digits_d = Digits;
      pend_dp_d     = Dp;
      pend_blank_d  = Blank;
      pend_blink_d  = Blink;
      pend_flag_d   = 1'b1;
    end

    anode_d   = '1;
    cathode_d = SEG_OFF;
    if (lit) begin
      anode_d   = ~(NUM_DIGITS'(1) << dig_q);
      cathode_d = {~act_dp_q[dig_q], cur_seg};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q         <= '0;
      sub_q         <= '0;
      dig_q         <= '0;
      blk_q         <= '0;
      phase_q       <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_blink_q  <= '0;
      pend_flag_q   <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      anode_q       <= '1;
      cathode_q     <= SEG_OFF;
      tick_q        <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      sub_q         <= sub_d;
      dig_q         <= dig_d;
      blk_q         <= blk_d;
      phase_q       <= phase_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      pend_flag_q   <= pend_flag_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      tick_q        <= frame_wrap;
    end
  end

  assign Anode     = anode_q;
  assign Cathode   = cathode_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomised self-checking bench for ssd_scan_driver against a time-indexed display model.
module tb_ssd_scan_driver;

  localparam int ND    = 4;
  localparam int SUB   = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 8 * SUB;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] SEG_TBL [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20,
                                          7'h0F, 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42,
                                          7'h30, 7'h38};

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          Load;
  logic [4*ND-1:0] Digits;
  logic [ND-1:0] Dp, Blank, Blink;
  logic [2:0]    Brightness;
  logic [ND-1:0] Anode;
  logic [7:0]    Cathode;
  logic          FrameTick;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ssd_scan_driver #(.NUM_DIGITS(ND), .SUB_DIV(SUB), .BLINK_FRAMES(BF)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Load       (Load),
    .Digits     (Digits),
    .Dp         (Dp),
    .Blank      (Blank),
    .Blink      (Blink),
    .Brightness (Brightness),
    .Anode      (Anode),
    .Cathode    (Cathode),
    .FrameTick  (FrameTick)
  );

  always #5 CLK = ~CLK;

  // Model: scan position is pure arithmetic on the number of clock edges since reset.
  int            n;
  logic [4*ND-1:0] m_pdig, m_adig;
  logic [ND-1:0] m_pdp, m_adp, m_pblank, m_ablank, m_pblink, m_ablink;
  bit            m_flag;
  logic [ND-1:0] exp_an;
  logic [7:0]    exp_ca;
  logic          exp_tick;

  always @(posedge CLK or negedge RST_N) begin
    int  sub, k, frames;
    bit  ph, lit, wrap;
    if (!RST_N) begin
      n <= 0;
      m_pdig <= '0; m_adig <= '0; m_pdp <= '0; m_adp <= '0;
      m_pblank <= '1; m_ablank <= '1; m_pblink <= '0; m_ablink <= '0;
      m_flag <= 1'b0;
      exp_an <= '1; exp_ca <= 8'hFF; exp_tick <= 1'b0;
    end else begin
      sub    = (n / SUB) % 8;
      k      = (n / SLOT) % ND;
      frames = n / FRAME;
      ph     = ((frames / BF) % 2) == 1;
      lit    = (sub <= int'(Brightness)) && !m_ablank[k] && !(m_ablink[k] && ph);
      wrap   = ((n + 1) % FRAME) == 0;
      exp_an   <= lit ? ~(ND'(1) << k) : '1;
      exp_ca   <= lit ? {~m_adp[k], SEG_TBL[m_adig[k*4 +: 4]]} : 8'hFF;
      exp_tick <= wrap;
      if (wrap && m_flag) begin
        m_adig <= m_pdig; m_adp <= m_pdp; m_ablank <= m_pblank; m_ablink <= m_pblink;
        m_flag <= 1'b0;
      end
      if (Load) begin
        m_pdig <= Digits; m_pdp <= Dp; m_pblank <= Blank; m_pblink <= Blink;
        m_flag <= 1'b1;
      end
      n <= n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if (Anode !== exp_an || Cathode !== exp_ca || FrameTick !== exp_tick ||
          $countones(~Anode) > 1) begin
        n_bad++;
        $display("FAIL model: got an=%h ca=%h tick=%b expected an=%h ca=%h tick=%b at %0t",
                 Anode, Cathode, FrameTick, exp_an, exp_ca, exp_tick, $time);
      end
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk);
    @(negedge CLK);
    Digits = d; Dp = dp; Blank = bl; Blink = bk; Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
  endtask

  task automatic wait_tick();
    int i;
    i = 0;
    do begin
      @(negedge CLK);
      i++;
    end while (!FrameTick && i < 200);
    if (!FrameTick) chk("frametick_timeout", 32'(i), 32'(FRAME));
  endtask

  task automatic count_low(input int cycles, input logic [3:0] an, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (an == 4'h0 ? (Anode != 4'hF) : (Anode == an)) cnt++;
    end
  endtask

  initial begin
    int cnt, last, gap, seen1;
    Load = 0; Digits = '0; Dp = '0; Blank = '0; Blink = '0; Brightness = 3'd7;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #20;
    @(negedge CLK);
    RST_N = 1'b1;
    chk_en = 1'b1;

    // Dark after reset, FrameTick every frame.
    cnt = 0; last = -1; gap = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (Anode != 4'hF || Cathode != 8'hFF) cnt++;
      if (FrameTick) begin
        if (last < 0) chk("first_tick", 32'(i), 32'(FRAME));
        else chk("tick_period", 32'(i - last), 32'(FRAME));
        last = i;
      end
    end
    chk("dark_after_reset", 32'(cnt), 32'd0);

    do_load(16'h3210, 4'h0, 4'h0, 4'h0);
    wait_tick();
    @(negedge CLK);
    chk("d0_an", 32'(Anode), 32'hE); chk("d0_ca", 32'(Cathode), 32'h81);
    repeat (SLOT) @(negedge CLK);
    chk("d1_an", 32'(Anode), 32'hD); chk("d1_ca", 32'(Cathode), 32'hCF);
    repeat (SLOT) @(negedge CLK);
    chk("d2_an", 32'(Anode), 32'hB); chk("d2_ca", 32'(Cathode), 32'h92);
    repeat (SLOT) @(negedge CLK);
    chk("d3_an", 32'(Anode), 32'h7); chk("d3_ca", 32'(Cathode), 32'h86);

    Brightness = 3'd0;
    repeat (20) @(negedge CLK);
    count_low(FRAME, 4'h0, cnt);
    chk("bright0_on", 32'(cnt), 32'd8);
    Brightness = 3'd3;
    repeat (20) @(negedge CLK);
    count_low(FRAME, 4'h0, cnt);
    chk("bright3_on", 32'(cnt), 32'd32);
    Brightness = 3'd7;

    do_load(16'h3210, 4'b0001, 4'h0, 4'b0010);
    wait_tick();
    @(negedge CLK);
    chk("dp_an", 32'(Anode), 32'hE); chk("dp_ca", 32'(Cathode), 32'h01);
    count_low(2 * BF * FRAME, 4'hD, cnt);
    chk("blink_d1_on", 32'(cnt), 32'(BF * SLOT));

    wait_tick();
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    repeat (5) @(negedge CLK);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    wait_tick();
    cnt = 0; seen1 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge CLK);
      if (Cathode == 8'hCF) seen1++;
      if (Cathode == 8'h92) cnt++;
    end
    chk("overwrite_1111_seen", 32'(seen1), 32'd0);
    chk("overwrite_2222_lit", 32'(cnt), 32'(2 * FRAME));

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 150)) @(negedge CLK);
      if ($urandom_range(0, 2) == 0) Brightness = 3'($urandom_range(0, 7));
      do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              4'($urandom));
    end
    repeat (300) @(negedge CLK);

    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_an", 32'(Anode), 32'hF);
    chk("rst_ca", 32'(Cathode), 32'hFF);
    chk("rst_tick", 32'(FrameTick), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    cnt = 0; last = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (Anode != 4'hF) cnt++;
      if (FrameTick && last < 0) last = i;
    end
    chk("dark_after_rst", 32'(cnt), 32'd0);
    chk("restart_tick", 32'(last), 32'(FRAME));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.
- Drives active-low anode and cathode lines.
- Adds features the fixed 4-digit driver lacks: atomic frame-aligned digit updates, per-digit blank, per-digit blink, per-digit decimal point, and 8-level PWM brightness.
- Sits between application logic (lock FSM, counters) and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4: digit count (2..8); width of Anode and per-digit buses.
- SUB_DIV, 12500: clocks per brightness sub-slot (>=1). One digit slot = 8*SUB_DIV clocks.
- BLINK_FRAMES, 64: full scan frames per blink half-period (>=1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- Load  in  1  single-cycle strobe; captures Digits/Dp/Blank/Blink into the pending register.
- Digits  in  4*NUM_DIGITS  hex value per digit; digit i = bits [4i+3:4i]; digit 0 = rightmost (AN0).
- Dp  in  NUM_DIGITS  1 = decimal point lit.
- Blank  in  NUM_DIGITS  1 = digit dark.
- Blink  in  NUM_DIGITS  1 = digit dark during blink-off phase.
- Brightness  in  3  on-time level; digit lit for (Brightness+1)/8 of its slot.
- Anode  out  NUM_DIGITS  active-low one-hot digit enable.
- Cathode  out  8  active-low segments: bit7 = DP, bits 6..0 = a,b,c,d,e,f,g.
- FrameTick  out  1  one-cycle pulse in the cycle the digit index wraps from NUM_DIGITS-1 to 0.

## Operation
- Prescaler counts 0..SUB_DIV-1. At its terminal count:
  - Sub-slot counter (3 bits, 0..7) advances.
  - When the sub-slot wraps 7->0, the digit index advances 0..NUM_DIGITS-1 and wraps.
- Frame boundary = digit index wrap.
  - Blink counter counts frames 0..BLINK_FRAMES-1.
  - On its wrap, blink phase toggles: 0 = on, 1 = off.
- Pending register: loaded on Load; a new Load overwrites it; sets the pending flag.
- Active register is the only set used for display.
  - Transferred from pending at a frame boundary when the flag is set; flag cleared in the same cycle.
  - Load coincident with a frame boundary: the new values land in pending and apply at the next boundary.
- Digit d at index k is lit iff all of the following hold; otherwise Anode is all ones and Cathode = 8'hFF:
  - sub-slot <= Brightness
  - Blank[k] = 0
  - not (Blink[k] and blink phase = 1)
- Lit digit outputs:
  - Anode = ~(1<<k).
  - Cathode[6:0] = hex segment code of Digits[k]: 0-9, A, b, C, d, E, F.
  - Cathode[7] = ~Dp[k].
- Brightness is sampled live, not through the pending register. A change takes effect at the next sub-slot.
- Reset values:
  - All counters 0; blink phase 0; pending flag 0.
  - Active and pending: Digits = 0, Dp = 0, Blank = all ones, Blink = 0.
  - Anode = all ones, Cathode = 8'hFF, FrameTick = 0.
  - The display is dark until the first Load has been applied.

## Timing
- Anode, Cathode and FrameTick are registered: one cycle after the counter state that selects them.
- Never more than one Anode bit low.
- Slot = 8*SUB_DIV clocks; frame = NUM_DIGITS*8*SUB_DIV clocks; blink period = 2*BLINK_FRAMES frames.
- Load-to-display latency: up to one frame, plus 1 cycle.
- RST_N assertion mid-scan forces reset values immediately, asynchronously. Deassertion restarts at digit 0, sub-slot 0.

## Structure
- Package ssd_pkg holds:
  - Segment constants: SEG_OFF = 8'hFF, DP bit index 7.
  - Hex-to-segment function for codes 0..F (bits 6..0, active-low).
- Sub-module ssd_hex_encode: combinational nibble-to-7-segment encoder built on the package function.
- Top holds:
  - Prescaler, sub-slot, digit and blink counters.
  - Pending/active registers.
  - Output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, SUB_DIV=2, BLINK_FRAMES=2 (slot 16 clocks, frame 64 clocks).
- Reset, no Load -> Anode=4'hF and Cathode=8'hFF for 200 cycles; FrameTick pulses every 64 cycles.
- Load Digits=16'h3210, Blank=0, Brightness=7 -> after the next FrameTick, Anode cycles E, D, B, 7 every 16 clocks. Cathode = 8'h81, 8'hCF, 8'h92, 8'h86.
- Brightness=0 -> each Anode low for exactly 2 of 16 clocks per slot; Brightness=3 -> low for 8.
- Blink=4'b0010, Dp=4'b0001 -> digit 1 dark on alternate 2-frame periods; digit 0 Cathode = 8'h01.
- Two Loads within one frame (16'h1111 then 16'h2222) -> only 16'h2222 is displayed after the boundary; 16'h1111 never appears.
- RST_N pulsed low mid-slot -> outputs return to reset values in the same cycle; the scan restarts at digit 0 with display dark.
